// File: rtl/key_event.sv
// key_event: press/release/long-press/auto-repeat pulses from a clean key level.
// Optional auto-repeat is compiled in when KEY_EVENT_REPEAT_EN is defined.
module key_event #(
  parameter int LONG_CMAX = 50_000_000,
  parameter int RPT_CMAX  = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic d_sig,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_rpt,
  output logic o_held
);

  localparam int CMAX =
    (LONG_CMAX > RPT_CMAX) ? LONG_CMAX : RPT_CMAX;
  localparam int CW = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] LONG_C = CW'(LONG_CMAX);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] FULL_C = {CW{1'b1}};

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CW-1:0] RPT_C = CW'(RPT_CMAX);
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHORT,
    LONG
  } state_t;

  state_t        state;
  logic          d_prev;
  logic [CW-1:0] cnt;

`ifdef KEY_EVENT_REPEAT_EN
  logic          rpt_q;
`endif

  // counter never wraps: it sticks at all-ones
  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] c
  );
    return (c == FULL_C) ? c : c + ONE_C;
  endfunction

  // key FSM with hold counter; every output is a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      d_prev    <= 1'b1;
      cnt       <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_held    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      rpt_q     <= 1'b0;
`endif
    end else begin
      d_prev    <= d_sig;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      rpt_q     <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // a level held since reset needs a fresh rising edge
          if (d_sig && !d_prev) begin
            state   <= SHORT;
            o_press <= 1'b1;
            o_held  <= 1'b1;
            cnt     <= ONE_C;
          end
        end
        SHORT: begin
          // release wins over a simultaneous long event
          if (!d_sig) begin
            state     <= IDLE;
            o_release <= 1'b1;
            o_held    <= 1'b0;
            cnt       <= '0;
          end else if (cnt == LONG_C) begin
            state  <= LONG;
            o_long <= 1'b1;
            cnt    <= ONE_C;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        LONG: begin
          if (!d_sig) begin
            state     <= IDLE;
            o_release <= 1'b1;
            o_held    <= 1'b0;
            cnt       <= '0;
          end else begin
`ifdef KEY_EVENT_REPEAT_EN
            if (cnt == RPT_C) begin
              rpt_q <= 1'b1;
              cnt   <= ONE_C;
            end else begin
              cnt <= sat_inc(cnt);
            end
`else
            cnt <= cnt;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          o_held <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  assign o_rpt = rpt_q;
`else
  assign o_rpt = 1'b0;
`endif

endmodule
